// File: rtl/gp_vector_sequencer.sv
// gp_vector_sequencer: walks one GP-Core vector op lane by lane, reading vs1/vs2 and writing vd a cycle later.
// Define GP_VSEQ_MASK_EN to add the per-lane write mask input (issue_mask).
module gp_vector_sequencer #(
  parameter int NUM_LANES  = 8,
  parameter int LANE_W     = 8,
  parameter int LANE_IDX_W = $clog2(NUM_LANES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [2:0]            issue_func,
  input  logic [2:0]            issue_vd,
  input  logic [2:0]            issue_vs1,
  input  logic [2:0]            issue_vs2,
  input  logic [LANE_IDX_W:0]   issue_vl,
`ifdef GP_VSEQ_MASK_EN
  input  logic [NUM_LANES-1:0]  issue_mask,
`endif
  input  logic                  flush,
  output logic                  vrf_rd_en,
  output logic [2:0]            vrf_rd_idx1,
  output logic [2:0]            vrf_rd_idx2,
  output logic [LANE_IDX_W-1:0] vrf_rd_lane,
  input  logic [LANE_W-1:0]     vrf_rd_data1,
  input  logic [LANE_W-1:0]     vrf_rd_data2,
  output logic                  vrf_wr_en,
  output logic [2:0]            vrf_wr_idx,
  output logic [LANE_IDX_W-1:0] vrf_wr_lane,
  output logic [LANE_W-1:0]     vrf_wr_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [LANE_IDX_W:0] VL_MAX = (LANE_IDX_W+1)'(NUM_LANES);

  state_t                state;
  logic [2:0]            func_q;
  logic [2:0]            vd_q;
  logic [2:0]            vs1_q;
  logic [2:0]            vs2_q;
  logic [LANE_IDX_W-1:0] vl_last_q;
  logic [LANE_IDX_W-1:0] rd_lane_q;
  logic [LANE_IDX_W-1:0] wr_lane_q;
  logic                  rd_en_q;
  logic                  wr_en_q;
  logic                  done_q;
  logic [LANE_IDX_W:0]   vl_clamp;
  logic [LANE_W-1:0]     alu_out;
  logic                  wr_gate;

  assign vl_clamp = (issue_vl > VL_MAX) ? VL_MAX : issue_vl;

  // Lane k's read is issued in RUN cycle k; its write follows one cycle later when the data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      func_q    <= '0;
      vd_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vl_last_q <= '0;
      rd_lane_q <= '0;
      wr_lane_q <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (issue_valid) begin
              func_q    <= issue_func;
              vd_q      <= issue_vd;
              vs1_q     <= issue_vs1;
              vs2_q     <= issue_vs2;
              rd_lane_q <= '0;
              if (vl_clamp == '0) begin
                vl_last_q <= '0;
                done_q    <= 1'b1;
                state     <= S_DONE;
              end else begin
                vl_last_q <= LANE_IDX_W'(vl_clamp - 1'b1);
                rd_en_q   <= 1'b1;
                state     <= S_RUN;
              end
            end
          end
          S_RUN: begin
            wr_en_q   <= 1'b1;
            wr_lane_q <= rd_lane_q;
            if (rd_lane_q == vl_last_q) begin
              done_q <= 1'b1;
              state  <= S_DRAIN;
            end else begin
              rd_en_q   <= 1'b1;
              rd_lane_q <= rd_lane_q + 1'b1;
            end
          end
          S_DRAIN: state <= S_IDLE;
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef GP_VSEQ_MASK_EN
  logic [NUM_LANES-1:0] mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (state == S_IDLE && issue_valid && !flush) begin
      mask_q <= issue_mask;
    end
  end

  assign wr_gate = wr_en_q & mask_q[wr_lane_q];
`else
  assign wr_gate = wr_en_q;
`endif

  always_comb begin
    alu_out = '0;
    unique case (func_q)
      3'd0: alu_out = vrf_rd_data1 + vrf_rd_data2;
      3'd1: alu_out = vrf_rd_data1 - vrf_rd_data2;
      3'd2: alu_out = vrf_rd_data1 & vrf_rd_data2;
      3'd3: alu_out = vrf_rd_data1 | vrf_rd_data2;
      3'd4: alu_out = vrf_rd_data1 ^ vrf_rd_data2;
      3'd5: alu_out = vrf_rd_data1 * vrf_rd_data2;
      3'd6: alu_out = (vrf_rd_data1 < vrf_rd_data2) ? vrf_rd_data1 : vrf_rd_data2;
      3'd7: alu_out = (vrf_rd_data1 > vrf_rd_data2) ? vrf_rd_data1 : vrf_rd_data2;
      default: alu_out = '0;
    endcase
  end

  // Flush kills any VRF access in its own cycle and turns an in-flight op into an abort pulse.
  assign busy        = (state != S_IDLE);
  assign issue_ready = (state == S_IDLE) && !flush;
  assign done        = flush ? busy : done_q;
  assign vrf_rd_en   = rd_en_q & ~flush;
  assign vrf_rd_idx1 = vs1_q;
  assign vrf_rd_idx2 = vs2_q;
  assign vrf_rd_lane = rd_lane_q;
  assign vrf_wr_en   = wr_gate & ~flush;
  assign vrf_wr_idx  = vd_q;
  assign vrf_wr_lane = wr_lane_q;
  assign vrf_wr_data = vrf_wr_en ? alu_out : '0;

endmodule

// File: tb/tb_gp_vector_sequencer.sv
// tb_gp_vector_sequencer: directed bench with a behavioural VRF and a write scoreboard.
// Exercises the GP_VSEQ_MASK_EN write mask only when that macro is defined.
module tb_gp_vector_sequencer;

  localparam int NUM_LANES  = 8;
  localparam int LANE_W     = 8;
  localparam int LANE_IDX_W = 3;

  typedef struct packed {
    logic [2:0] idx;
    logic [2:0] lane;
    logic [7:0] data;
  } wr_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  issue_valid = 1'b0;
  logic                  issue_ready;
  logic [2:0]            issue_func = '0;
  logic [2:0]            issue_vd = '0;
  logic [2:0]            issue_vs1 = '0;
  logic [2:0]            issue_vs2 = '0;
  logic [LANE_IDX_W:0]   issue_vl = '0;
  logic [NUM_LANES-1:0]  issue_mask = '1;
  logic                  flush = 1'b0;
  logic                  vrf_rd_en;
  logic [2:0]            vrf_rd_idx1;
  logic [2:0]            vrf_rd_idx2;
  logic [LANE_IDX_W-1:0] vrf_rd_lane;
  logic [LANE_W-1:0]     vrf_rd_data1 = '0;
  logic [LANE_W-1:0]     vrf_rd_data2 = '0;
  logic                  vrf_wr_en;
  logic [2:0]            vrf_wr_idx;
  logic [LANE_IDX_W-1:0] vrf_wr_lane;
  logic [LANE_W-1:0]     vrf_wr_data;
  logic                  busy;
  logic                  done;

  logic [7:0]           vrf [8][NUM_LANES];
  logic [NUM_LANES-1:0] cur_mask = '1;
  wr_t                  sb_q [$];
  int                   total = 0;
  int                   bad = 0;

  always #5 clk = ~clk;

  gp_vector_sequencer #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_func   (issue_func),
    .issue_vd     (issue_vd),
    .issue_vs1    (issue_vs1),
    .issue_vs2    (issue_vs2),
    .issue_vl     (issue_vl),
`ifdef GP_VSEQ_MASK_EN
    .issue_mask   (issue_mask),
`endif
    .flush        (flush),
    .vrf_rd_en    (vrf_rd_en),
    .vrf_rd_idx1  (vrf_rd_idx1),
    .vrf_rd_idx2  (vrf_rd_idx2),
    .vrf_rd_lane  (vrf_rd_lane),
    .vrf_rd_data1 (vrf_rd_data1),
    .vrf_rd_data2 (vrf_rd_data2),
    .vrf_wr_en    (vrf_wr_en),
    .vrf_wr_idx   (vrf_wr_idx),
    .vrf_wr_lane  (vrf_wr_lane),
    .vrf_wr_data  (vrf_wr_data),
    .busy         (busy),
    .done         (done)
  );

  // Registered VRF read port: data for a request appears one cycle later.
  always @(posedge clk) begin
    if (vrf_rd_en) begin
      vrf_rd_data1 <= vrf[vrf_rd_idx1][vrf_rd_lane];
      vrf_rd_data2 <= vrf[vrf_rd_idx2][vrf_rd_lane];
    end
  end

  function automatic logic [7:0] ref_alu(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    case (f)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: begin p = a * b; return p[7:0]; end
      3'd6: return (a < b) ? a : b;
      default: return (a > b) ? a : b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op, pushes its expected writes, and returns in the first cycle after the accept edge.
  task automatic apply_stimulus(input logic [2:0] f, input logic [2:0] vd, input logic [2:0] vs1,
                                input logic [2:0] vs2, input logic [3:0] vl, input logic [7:0] mask);
    int eff;
    @(negedge clk);
    issue_func  = f;
    issue_vd    = vd;
    issue_vs1   = vs1;
    issue_vs2   = vs2;
    issue_vl    = vl;
    issue_mask  = mask;
    cur_mask    = mask;
    issue_valid = 1'b1;
    eff = (vl > 4'd8) ? 8 : int'(vl);
    for (int i = 0; i < eff; i++) begin
      if (mask[i]) sb_q.push_back('{vd, i[2:0], ref_alu(f, vrf[vs1][i], vrf[vs2][i])});
    end
    check("ready_at_issue", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic check_write(input string tag);
    wr_t e;
    if (vrf_wr_en) begin
      check({tag, "_write_expected"}, sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check({tag, "_write"}, {vrf_wr_idx, vrf_wr_lane, vrf_wr_data}, e);
      end
    end
  endtask

  task automatic check_output(input string tag, input int c, input int eff);
    logic exp_wr;
    exp_wr = (c >= 2) ? cur_mask[c-2] : 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_rd_en"}, vrf_rd_en, c <= eff);
    if (c <= eff) check({tag, "_rd_lane"}, vrf_rd_lane, c - 1);
    check({tag, "_done"}, done, c == eff + 1);
    check({tag, "_wr_en"}, vrf_wr_en, exp_wr);
    check_write(tag);
  endtask

  task automatic run_op(input string tag, input int eff);
    for (int c = 1; c <= eff + 1; c++) begin
      check_output(tag, c, eff);
      tick();
    end
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_done_end"}, done, 0);
    check({tag, "_ready_end"}, issue_ready, 1);
    check({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  initial begin
    for (int r = 0; r < 8; r++)
      for (int l = 0; l < NUM_LANES; l++) vrf[r][l] = 8'($urandom);
    for (int l = 0; l < NUM_LANES; l++) begin
      vrf[1][l] = 8'(l + 1);
      vrf[2][l] = 8'd10;
    end
    vrf[4][0] = 8'h05;
    vrf[5][0] = 8'h07;
    vrf[6][0] = 8'h20;
    vrf[7][0] = 8'h10;

    // Reset values
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", vrf_rd_en, 0);
    check("rst_wr_en", vrf_wr_en, 0);
    check("rst_wr_data", vrf_wr_data, 0);
    check("rst_rd_lane", vrf_rd_lane, 0);
    check("rst_wr_idx", vrf_wr_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", issue_ready, 1);

    // ADD, full vector: lanes become 11..18
    apply_stimulus(3'd0, 3'd3, 3'd1, 3'd2, 4'd8, 8'hFF);
    run_op("add_vl8", 8);

    // Single-lane SUB (wraps to 0xFE) and MUL (low byte 0x00)
    apply_stimulus(3'd1, 3'd0, 3'd4, 3'd5, 4'd1, 8'hFF);
    run_op("sub_vl1", 1);
    apply_stimulus(3'd5, 3'd1, 3'd6, 3'd7, 4'd1, 8'hFF);
    run_op("mul_vl1", 1);

    // Remaining lane operations against random data
    for (int f = 2; f < 8; f++) begin
      apply_stimulus(3'(f), 3'd4, 3'd1, 3'd0, 4'd8, 8'hFF);
      run_op($sformatf("func%0d", f), 8);
    end

    // Zero-length op, then an over-long one that clamps to 8 lanes
    apply_stimulus(3'd0, 3'd5, 3'd1, 3'd2, 4'd0, 8'hFF);
    run_op("vl0", 0);
    apply_stimulus(3'd4, 3'd5, 3'd0, 3'd1, 4'd12, 8'hFF);
    run_op("vl12", 8);

    // Flush in the cycle that reads lane 3
    apply_stimulus(3'd0, 3'd6, 3'd1, 3'd2, 4'd8, 8'hFF);
    for (int c = 1; c <= 3; c++) begin
      check_output("flush_pre", c, 8);
      tick();
    end
    flush = 1'b1;
    issue_valid = 1'b1;
    #1;
    check("flush_rd_en", vrf_rd_en, 0);
    check("flush_wr_en", vrf_wr_en, 0);
    check("flush_done", done, 1);
    check("flush_busy", busy, 1);
    check("flush_ready", issue_ready, 0);
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    #1;
    check("flush_ready_after", issue_ready, 1);
    check("flush_busy_after", busy, 0);
    check("flush_pending", sb_q.size(), 6);
    sb_q.delete();
    tick();
    check("flush_not_accepted", busy, 0);

    // Asynchronous reset while lane 4 is being read
    apply_stimulus(3'd0, 3'd7, 3'd1, 3'd2, 4'd8, 8'hFF);
    for (int c = 1; c <= 4; c++) begin
      check_output("rst_mid_pre", c, 8);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_rd_en", vrf_rd_en, 0);
    check("rst_mid_wr_en", vrf_wr_en, 0);
    check("rst_mid_wr_lane", vrf_wr_lane, 0);
    check("rst_mid_pending", sb_q.size(), 5);
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_mid_no_wr", vrf_wr_en, 0);
      check("rst_mid_no_done", done, 0);
    end

`ifdef GP_VSEQ_MASK_EN
    // Write mask keeps only the odd lanes
    apply_stimulus(3'd0, 3'd3, 3'd1, 3'd2, 4'd8, 8'b10101010);
    run_op("mask_odd", 8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
